// File: rtl/w5300_interrupt_handler.sv
// W5300 /INT service engine: reads and clears chip IR, then walks every
// flagged and enabled socket, reads Sn_IR, writes it back to clear it, and
// hands the flags upstream as one event per socket.
module w5300_interrupt_handler #(
  parameter logic [7:0] SOCK_MASK   = 8'h01,
  parameter int         HOLDOFF     = 16,
  parameter int         RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [26:0] cmd,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_sock,
  output logic [7:0]  evt_flags,
  output logic        chip_ir_valid,
  output logic [7:0]  chip_ir,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_IR, S_W_IR, S_CLR_IR, S_SCAN,
    S_RD_SIR, S_W_SIR, S_WR_SIR, S_EVT, S_HOLD
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
  localparam logic [15:0] TO_LAST   = 16'(RSP_TIMEOUT - 1);
  localparam logic [9:0]  IR_ADDR   = 10'h002;

  function automatic logic [9:0] sir_addr(input logic [2:0] n);
    return 10'h206 + {1'b0, n, 6'b0};
  endfunction

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [7:0]  pend_q, pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [26:0] cmd_q, cmd_d;
  logic        evt_valid_q, evt_valid_d;
  logic [2:0]  evt_sock_q, evt_sock_d;
  logic [7:0]  evt_flags_q, evt_flags_d;
  logic        chip_ir_valid_q, chip_ir_valid_d;
  logic [7:0]  chip_ir_q, chip_ir_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic [2:0]  low_idx;

  // Two-flop synchronizer for the asynchronous /INT pin; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= int_n;
      sync2_q <= sync1_q;
    end
  end

  // Lowest pending socket, so sockets are serviced in ascending order.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--)
      if (pend_q[i]) low_idx = 3'(i);
  end

  // Next state; every output is registered, so it is set on the transition
  // into the state that owns it.
  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    cnt_d           = cnt_q;
    cmd_valid_d     = cmd_valid_q;
    cmd_d           = cmd_q;
    evt_valid_d     = evt_valid_q;
    evt_sock_d      = evt_sock_q;
    evt_flags_d     = evt_flags_q;
    chip_ir_valid_d = 1'b0;
    chip_ir_d       = chip_ir_q;
    timeout_d       = 1'b0;
    case (state_q)
      S_IDLE: if (!sync2_q) begin
        state_d     = S_RD_IR;
        cmd_valid_d = 1'b1;
        cmd_d       = {1'b1, IR_ADDR, 16'hffff};
      end
      S_RD_IR: if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_W_IR;
      end
      S_W_IR: begin
        if (rsp_valid) begin
          pend_d    = rsp_data[7:0] & SOCK_MASK;
          chip_ir_d = rsp_data[15:8];
          if (rsp_data[15:8] != 8'h00) begin
            chip_ir_valid_d = 1'b1;
            cmd_valid_d     = 1'b1;
            cmd_d           = {1'b0, IR_ADDR, rsp_data[15:8], 8'h00};
            state_d         = S_CLR_IR;
          end else begin
            state_d = S_SCAN;
          end
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          pend_d    = '0;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CLR_IR: if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        state_d     = S_SCAN;
      end
      S_SCAN: begin
        if (pend_q == 8'h00) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          evt_sock_d  = low_idx;
          cmd_valid_d = 1'b1;
          cmd_d       = {1'b1, sir_addr(low_idx), 16'hffff};
          state_d     = S_RD_SIR;
        end
      end
      S_RD_SIR: if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_W_SIR;
      end
      S_W_SIR: begin
        if (rsp_valid) begin
          evt_flags_d = rsp_data[7:0];
          if (rsp_data[7:0] == 8'h00) begin
            // Socket flagged in IR but nothing left in Sn_IR: skip it.
            pend_d[evt_sock_q] = 1'b0;
            state_d            = S_SCAN;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_d       = {1'b0, sir_addr(evt_sock_q), 8'h00, rsp_data[7:0]};
            state_d     = S_WR_SIR;
          end
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          pend_d    = '0;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WR_SIR: if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        evt_valid_d = 1'b1;
        state_d     = S_EVT;
      end
      S_EVT: if (evt_ready) begin
        evt_valid_d        = 1'b0;
        pend_d[evt_sock_q] = 1'b0;
        state_d            = S_SCAN;
      end
      S_HOLD: begin
        // /INT is ignored here so a still-low pin is not re-serviced at once.
        if (cnt_q == HOLD_LAST) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = !(state_d == S_IDLE || state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pend_q          <= '0;
      cnt_q           <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_q           <= '0;
      evt_valid_q     <= 1'b0;
      evt_sock_q      <= '0;
      evt_flags_q     <= '0;
      chip_ir_valid_q <= 1'b0;
      chip_ir_q       <= '0;
      timeout_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      cnt_q           <= cnt_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_q           <= cmd_d;
      evt_valid_q     <= evt_valid_d;
      evt_sock_q      <= evt_sock_d;
      evt_flags_q     <= evt_flags_d;
      chip_ir_valid_q <= chip_ir_valid_d;
      chip_ir_q       <= chip_ir_d;
      timeout_q       <= timeout_d;
      busy_q          <= busy_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd           = cmd_q;
  assign evt_valid     = evt_valid_q;
  assign evt_sock      = evt_sock_q;
  assign evt_flags     = evt_flags_q;
  assign chip_ir_valid = chip_ir_valid_q;
  assign chip_ir       = chip_ir_q;
  assign timeout       = timeout_q;
  assign busy          = busy_q;

endmodule
